// File: rtl/uart_fifo_bridge.sv
// CPU-to-uart bridge: 16-entry TX/RX FIFOs plus a bus-master engine that feeds the uart.
// Optional interrupt logic is built only when UART_FIFO_IRQ_EN is defined.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data_write,
    output logic [7:0] cpu_data_read,
    input  logic       cpu_ds,
    input  logic       cpu_rw,
    output logic       cpu_ack,
    output logic [7:0] u_addr,
    output logic [7:0] u_data_write,
    input  logic [7:0] u_data_read,
    output logic       u_ds,
    output logic       u_rw,
    input  logic       u_ack,
    input  logic       u_rx_avail,
    output logic       u_rx_avail_clear,
    output logic       irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, RX_RD, RX_CLR, TX_POLL, TX_WR, DROP} state_t;

    state_t state_q, state_d;
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];
    logic cpu_ack_q, cpu_ack_d;
    logic [7:0] cpu_data_read_q, cpu_data_read_d;
    logic rx_overrun_q, rx_overrun_d;
    logic u_ds_q, u_ds_d, u_rw_q, u_rw_d, u_clear_q, u_clear_d;
    logic [7:0] u_addr_q, u_addr_d, u_data_write_q, u_data_write_d;
    logic to_tx_q, to_tx_d;
    logic tx_empty, tx_full, rx_nonempty, rx_full;
    logic cpu_access, cpu_rd, cpu_wr, tx_push, tx_pop, rx_push, rx_pop, overrun_set;
    logic irq_bit;
    logic [7:0] status;
    logic unused_addr_bits;

`ifdef UART_FIFO_IRQ_EN
    logic irq_en_q, irq_en_d, txe_latch_q, txe_latch_d, irq_q, irq_d;
    assign irq_bit = irq_en_q;
    assign irq = irq_q;
`else
    assign irq_bit = 1'b0;
    assign irq = 1'b0;
`endif

    assign unused_addr_bits = ^cpu_addr[7:1];

    assign tx_empty    = (tx_wr_q == tx_rd_q);
    assign tx_full     = (tx_wr_q[PW-1] != tx_rd_q[PW-1]) &&
                         (tx_wr_q[DEPTH_LOG2-1:0] == tx_rd_q[DEPTH_LOG2-1:0]);
    assign rx_nonempty = (rx_wr_q != rx_rd_q);
    assign rx_full     = (rx_wr_q[PW-1] != rx_rd_q[PW-1]) &&
                         (rx_wr_q[DEPTH_LOG2-1:0] == rx_rd_q[DEPTH_LOG2-1:0]);
    assign status = {3'b000, irq_bit, tx_empty, rx_overrun_q, tx_full, rx_nonempty};

    // An access executes only on the first cycle of a strobe; ack blocks repeats.
    assign cpu_access = cpu_ds && !cpu_ack_q;
    assign cpu_rd     = cpu_access && cpu_rw;
    assign cpu_wr     = cpu_access && !cpu_rw;
    assign tx_push    = cpu_wr && !cpu_addr[0] && !tx_full;
    assign rx_pop     = cpu_rd && !cpu_addr[0] && rx_nonempty;

    always_comb begin
        cpu_ack_d       = cpu_ds;
        cpu_data_read_d = cpu_data_read_q;
        rx_overrun_d    = rx_overrun_q;
        tx_wr_d         = tx_wr_q + (tx_push ? PW'(1) : PW'(0));
        tx_rd_d         = tx_rd_q + (tx_pop ? PW'(1) : PW'(0));
        rx_wr_d         = rx_wr_q + (rx_push ? PW'(1) : PW'(0));
        rx_rd_d         = rx_rd_q + (rx_pop ? PW'(1) : PW'(0));
        if (cpu_rd) begin
            if (cpu_addr[0])
                cpu_data_read_d = status;
            else
                cpu_data_read_d = rx_nonempty ? rx_mem_q[rx_rd_q[DEPTH_LOG2-1:0]] : 8'h00;
        end
        if (overrun_set)
            rx_overrun_d = 1'b1;
        else if (cpu_wr && cpu_addr[0] && cpu_data_write[2])
            rx_overrun_d = 1'b0;
`ifdef UART_FIFO_IRQ_EN
        irq_en_d    = irq_en_q;
        txe_latch_d = txe_latch_q;
        if (cpu_wr && cpu_addr[0])
            irq_en_d = cpu_data_write[4];
        if (!tx_empty && (tx_wr_d == tx_rd_d))
            txe_latch_d = 1'b1;
        else if (cpu_rd && cpu_addr[0])
            txe_latch_d = 1'b0;
        irq_d = irq_en_q && (rx_nonempty || rx_overrun_q || txe_latch_q);
`endif
    end

    // Engine: one uart access at a time, RX has priority whenever it is back in IDLE.
    always_comb begin
        state_d        = state_q;
        u_ds_d         = u_ds_q;
        u_rw_d         = u_rw_q;
        u_addr_d       = u_addr_q;
        u_data_write_d = u_data_write_q;
        u_clear_d      = 1'b0;
        to_tx_d        = to_tx_q;
        tx_pop         = 1'b0;
        rx_push        = 1'b0;
        overrun_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (u_rx_avail) begin
                    state_d  = RX_RD;
                    u_ds_d   = 1'b1;
                    u_rw_d   = 1'b1;
                    u_addr_d = 8'd0;
                end else if (!tx_empty) begin
                    state_d  = TX_POLL;
                    u_ds_d   = 1'b1;
                    u_rw_d   = 1'b1;
                    u_addr_d = 8'd1;
                end
            end
            RX_RD: begin
                if (u_ack) begin
                    u_ds_d    = 1'b0;
                    u_clear_d = 1'b1;
                    state_d   = RX_CLR;
                    if (rx_full)
                        overrun_set = 1'b1;
                    else
                        rx_push = 1'b1;
                end
            end
            RX_CLR: begin
                to_tx_d = 1'b0;
                state_d = DROP;
            end
            TX_POLL: begin
                if (u_ack) begin
                    u_ds_d  = 1'b0;
                    to_tx_d = !u_data_read[1];
                    state_d = DROP;
                end
            end
            TX_WR: begin
                if (u_ack) begin
                    u_ds_d  = 1'b0;
                    u_rw_d  = 1'b1;
                    tx_pop  = 1'b1;
                    to_tx_d = 1'b0;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!u_ack) begin
                    if (to_tx_q) begin
                        state_d        = TX_WR;
                        u_ds_d         = 1'b1;
                        u_rw_d         = 1'b0;
                        u_addr_d       = 8'd0;
                        u_data_write_d = tx_mem_q[tx_rd_q[DEPTH_LOG2-1:0]];
                        to_tx_d        = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            tx_wr_q         <= '0;
            tx_rd_q         <= '0;
            rx_wr_q         <= '0;
            rx_rd_q         <= '0;
            cpu_ack_q       <= 1'b0;
            cpu_data_read_q <= 8'h00;
            rx_overrun_q    <= 1'b0;
            u_ds_q          <= 1'b0;
            u_rw_q          <= 1'b1;
            u_addr_q        <= 8'h00;
            u_data_write_q  <= 8'h00;
            u_clear_q       <= 1'b0;
            to_tx_q         <= 1'b0;
`ifdef UART_FIFO_IRQ_EN
            irq_en_q        <= 1'b0;
            txe_latch_q     <= 1'b0;
            irq_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            tx_wr_q         <= tx_wr_d;
            tx_rd_q         <= tx_rd_d;
            rx_wr_q         <= rx_wr_d;
            rx_rd_q         <= rx_rd_d;
            cpu_ack_q       <= cpu_ack_d;
            cpu_data_read_q <= cpu_data_read_d;
            rx_overrun_q    <= rx_overrun_d;
            u_ds_q          <= u_ds_d;
            u_rw_q          <= u_rw_d;
            u_addr_q        <= u_addr_d;
            u_data_write_q  <= u_data_write_d;
            u_clear_q       <= u_clear_d;
            to_tx_q         <= to_tx_d;
`ifdef UART_FIFO_IRQ_EN
            irq_en_q        <= irq_en_d;
            txe_latch_q     <= txe_latch_d;
            irq_q           <= irq_d;
`endif
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem_q[tx_wr_q[DEPTH_LOG2-1:0]] <= cpu_data_write;
        if (rx_push)
            rx_mem_q[rx_wr_q[DEPTH_LOG2-1:0]] <= u_data_read;
    end

    assign cpu_ack          = cpu_ack_q;
    assign cpu_data_read    = cpu_data_read_q;
    assign u_ds             = u_ds_q;
    assign u_rw             = u_rw_q;
    assign u_addr           = u_addr_q;
    assign u_data_write     = u_data_write_q;
    assign u_rx_avail_clear = u_clear_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a small uart slave model; irq expectations
// follow whether UART_FIFO_IRQ_EN is defined.
module tb_uart_fifo_bridge;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cpu_addr = 8'h00;
    logic [7:0] cpu_data_write = 8'h00;
    logic [7:0] cpu_data_read;
    logic       cpu_ds = 1'b0;
    logic       cpu_rw = 1'b1;
    logic       cpu_ack;
    logic [7:0] u_addr;
    logic [7:0] u_data_write;
    logic [7:0] u_data_read = 8'h00;
    logic       u_ds;
    logic       u_rw;
    logic       u_ack = 1'b0;
    logic       u_rx_avail = 1'b0;
    logic       u_rx_avail_clear;
    logic       irq;

    int checks = 0;
    int errors = 0;

    // uart model state
    logic [7:0] rx_byte = 8'h00;
    logic       busy_hold = 1'b0;
    int         busy_limit = 0;
    int         poll_count = 0;
    int         rx_reads = 0;
    int         clear_count = 0;
    int         tx_cnt = 0;
    int         seq_err = 0;
    int         bad_access = 0;
    logic       last_poll_ok = 1'b0;
    logic [7:0] tx_log [64];

`ifdef UART_FIFO_IRQ_EN
    localparam logic IRQ_BUILT = 1'b1;
`else
    localparam logic IRQ_BUILT = 1'b0;
`endif

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_data_write(cpu_data_write), .cpu_data_read(cpu_data_read),
        .cpu_ds(cpu_ds), .cpu_rw(cpu_rw), .cpu_ack(cpu_ack),
        .u_addr(u_addr), .u_data_write(u_data_write), .u_data_read(u_data_read),
        .u_ds(u_ds), .u_rw(u_rw), .u_ack(u_ack), .u_rx_avail(u_rx_avail),
        .u_rx_avail_clear(u_rx_avail_clear), .irq(irq)
    );

    always #5 clk = ~clk;

    // Slave model: ack one cycle after ds, hold while ds, release after ds drops.
    always @(posedge clk) begin
        if (u_rx_avail_clear)
            clear_count <= clear_count + 1;
        if (!u_ds) begin
            u_ack <= 1'b0;
        end else if (!u_ack) begin
            u_ack <= 1'b1;
            if (u_rw && u_addr == 8'd1) begin
                u_data_read  <= (busy_hold || poll_count < busy_limit) ? 8'h02 : 8'h00;
                last_poll_ok <= !(busy_hold || poll_count < busy_limit);
                poll_count   <= poll_count + 1;
            end else if (u_rw && u_addr == 8'd0) begin
                u_data_read <= rx_byte;
                rx_reads    <= rx_reads + 1;
            end else if (!u_rw && u_addr == 8'd0) begin
                if (tx_cnt < 64)
                    tx_log[tx_cnt] <= u_data_write;
                tx_cnt <= tx_cnt + 1;
                if (!last_poll_ok)
                    seq_err <= seq_err + 1;
                last_poll_ok <= 1'b0;
            end else begin
                bad_access <= bad_access + 1;
            end
        end
    end

    task automatic cpu_xfer(input logic [7:0] addr, input logic rw, input logic [7:0] wdata,
                            output logic [7:0] rdata, output int lat);
        @(negedge clk);
        cpu_addr = addr;
        cpu_rw = rw;
        cpu_data_write = wdata;
        cpu_ds = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 10);
        if (!cpu_ack) begin
            errors++;
            $display("[TB] FAIL cpu_ack_timeout got=0 want=1");
        end
        rdata = cpu_data_read;
        cpu_ds = 1'b0;
        @(negedge clk);
    endtask

    task automatic inject_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_byte = b;
        u_rx_avail = 1'b1;
        n = 0;
        while (!u_rx_avail_clear && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!u_rx_avail_clear) begin
            errors++;
            $display("[TB] FAIL rx_clear_timeout got=0 want=1");
        end
        u_rx_avail = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n;
        n = 0;
        while (tx_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_cnt < target) begin
            errors++;
            $display("[TB] FAIL tx_timeout got=%0d want=%0d", tx_cnt, target);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        int lat;
        checks++;
        if ({cpu_ack, cpu_data_read, u_ds, u_rw, u_addr, u_data_write, u_rx_avail_clear, irq}
            !== {1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values got ack=%b rd=%h ds=%b rw=%b addr=%h wd=%h clr=%b irq=%b",
                     cpu_ack, cpu_data_read, u_ds, u_rw, u_addr, u_data_write, u_rx_avail_clear, irq);
        end
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h08) begin errors++; $display("[TB] FAIL reset_status got=%h want=08", d); end
        checks++;
        if (lat !== 1) begin errors++; $display("[TB] FAIL ack_latency got=%0d want=1", lat); end
        checks++;
        if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_release got=%b want=0", cpu_ack); end
        checks++;
        if (cpu_data_read !== 8'h08) begin
            errors++; $display("[TB] FAIL read_hold got=%h want=08", cpu_data_read);
        end
    endtask

    task automatic test_tx_basic;
        logic [7:0] d;
        int lat, p0, t0;
        p0 = poll_count;
        t0 = tx_cnt;
        busy_limit = poll_count + 3;
        cpu_xfer(8'h00, 1'b0, 8'h41, d, lat);
        cpu_xfer(8'h00, 1'b0, 8'h42, d, lat);
        wait_tx(t0 + 2, 300);
        repeat (10) @(negedge clk);
        checks++;
        if (tx_cnt - t0 !== 2) begin errors++; $display("[TB] FAIL tx_count got=%0d want=2", tx_cnt - t0); end
        checks++;
        if (tx_log[t0] !== 8'h41 || tx_log[t0+1] !== 8'h42) begin
            errors++; $display("[TB] FAIL tx_bytes got=%h,%h want=41,42", tx_log[t0], tx_log[t0+1]);
        end
        checks++;
        if (poll_count - p0 !== 5) begin
            errors++; $display("[TB] FAIL tx_polls got=%0d want=5", poll_count - p0);
        end
        checks++;
        if (seq_err !== 0 || bad_access !== 0) begin
            errors++; $display("[TB] FAIL tx_sequence got seq=%0d bad=%0d want 0,0", seq_err, bad_access);
        end
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h08) begin errors++; $display("[TB] FAIL tx_end_status got=%h want=08", d); end
    endtask

    task automatic test_rx_basic;
        logic [7:0] d;
        int lat, r0, c0;
        r0 = rx_reads;
        c0 = clear_count;
        inject_byte(8'h5A);
        repeat (5) @(negedge clk);
        checks++;
        if (rx_reads - r0 !== 1 || clear_count - c0 !== 1) begin
            errors++; $display("[TB] FAIL rx_access got reads=%0d clears=%0d want 1,1", rx_reads - r0, clear_count - c0);
        end
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h09) begin errors++; $display("[TB] FAIL rx_status got=%h want=09", d); end
        cpu_xfer(8'h00, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("[TB] FAIL rx_pop got=%h want=5a", d); end
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h08) begin errors++; $display("[TB] FAIL rx_after_status got=%h want=08", d); end
    endtask

    task automatic test_rx_overrun;
        logic [7:0] d;
        int lat;
        for (int i = 1; i <= 17; i++)
            inject_byte(8'(i));
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h0D) begin errors++; $display("[TB] FAIL overrun_status got=%h want=0d", d); end
        for (int i = 1; i <= 16; i++) begin
            cpu_xfer(8'h00, 1'b1, 8'h00, d, lat);
            checks++;
            if (d !== 8'(i)) begin errors++; $display("[TB] FAIL rx_order[%0d] got=%h want=%h", i, d, 8'(i)); end
        end
        cpu_xfer(8'h00, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL empty_pop got=%h want=00", d); end
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h0C) begin errors++; $display("[TB] FAIL drained_status got=%h want=0c", d); end
        cpu_xfer(8'h01, 1'b0, 8'h04, d, lat);
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h08) begin errors++; $display("[TB] FAIL overrun_clear got=%h want=08", d); end
    endtask

    task automatic test_tx_full;
        logic [7:0] d;
        int lat, t0;
        t0 = tx_cnt;
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++)
            cpu_xfer(8'h00, 1'b0, 8'h80 + 8'(i), d, lat);
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h02) begin errors++; $display("[TB] FAIL full_status got=%h want=02", d); end
        cpu_xfer(8'h00, 1'b0, 8'hEE, d, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("[TB] FAIL full_write_ack got=%0d want=1", lat); end
        busy_hold = 1'b0;
        wait_tx(t0 + 16, 800);
        repeat (30) @(negedge clk);
        checks++;
        if (tx_cnt - t0 !== 16) begin errors++; $display("[TB] FAIL full_count got=%0d want=16", tx_cnt - t0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_log[t0+i] !== 8'h80 + 8'(i)) begin
                errors++; $display("[TB] FAIL full_byte[%0d] got=%h want=%h", i, tx_log[t0+i], 8'h80 + 8'(i));
            end
        end
        checks++;
        if (seq_err !== 0 || bad_access !== 0) begin
            errors++; $display("[TB] FAIL full_sequence got seq=%0d bad=%0d want 0,0", seq_err, bad_access);
        end
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h08) begin errors++; $display("[TB] FAIL full_end_status got=%h want=08", d); end
    endtask

    task automatic test_irq;
        logic [7:0] d;
        int lat;
        cpu_xfer(8'h01, 1'b0, 8'h10, d, lat);
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== (IRQ_BUILT ? 8'h18 : 8'h08)) begin
            errors++; $display("[TB] FAIL irq_en_status got=%h want=%h", d, IRQ_BUILT ? 8'h18 : 8'h08);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_quiet got=%b want=0", irq); end
        inject_byte(8'h33);
        checks++;
        if (irq !== IRQ_BUILT) begin errors++; $display("[TB] FAIL irq_rx got=%b want=%b", irq, IRQ_BUILT); end
        cpu_xfer(8'h00, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h33) begin errors++; $display("[TB] FAIL irq_pop got=%h want=33", d); end
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear got=%b want=0", irq); end
        cpu_xfer(8'h01, 1'b0, 8'h00, d, lat);
    endtask

    task automatic test_reset_mid_access;
        logic [7:0] d;
        int lat, n, t0;
        t0 = tx_cnt;
        busy_hold = 1'b1;
        cpu_xfer(8'h00, 1'b0, 8'h77, d, lat);
        n = 0;
        while (!u_ds && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (u_ds !== 1'b1) begin errors++; $display("[TB] FAIL mid_access_start got=%b want=1", u_ds); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (u_ds !== 1'b0 || u_rw !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset got ds=%b rw=%b want 0,1", u_ds, u_rw);
        end
        @(negedge clk);
        busy_hold = 1'b0;
        reset_n = 1'b1;
        cpu_xfer(8'h01, 1'b1, 8'h00, d, lat);
        checks++;
        if (d !== 8'h08) begin errors++; $display("[TB] FAIL reset_flush got=%h want=08", d); end
        repeat (20) @(negedge clk);
        checks++;
        if (tx_cnt !== t0) begin errors++; $display("[TB] FAIL reset_no_tx got=%0d want=%0d", tx_cnt, t0); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_tx_basic;
        test_rx_basic;
        test_rx_overrun;
        test_tx_full;
        test_irq;
        test_reset_mid_access;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
